// File: rtl/fetch_defs.sv
// Shared definitions for the fetch sequencer: FSM states, buffer entry, reset constants.
package fetch_defs;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StDrain,
    StHalted
  } fetch_state_e;

  localparam logic [15:0] DefResetPc = 16'h0000;
  localparam logic [15:0] DefNopInst = 16'h0800;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } fetch_entry_t;

  // Instructions are halfword aligned; bit 0 of a target is dropped.
  function automatic logic [15:0] align_pc(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry instruction buffer: main drives IF/ID, skid absorbs one response
// that arrives while main is held by a downstream stall.
module fetch_skid_buf
  import fetch_defs::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  output fetch_entry_t main_entry_o,
  output logic         valid_o,
  output logic         full_o
);

  fetch_entry_t main_q, main_d;
  fetch_entry_t skid_q, skid_d;
  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;

  // Next-state for both entries: flush wins, then pop/shift, then push.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (pop_i) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
        if (push_i) begin
          skid_d     = push_entry_i;
          skid_vld_d = 1'b1;
        end
      end else if (push_i) begin
        main_d     = push_entry_i;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (push_i) begin
      if (!main_vld_q) begin
        main_d     = push_entry_i;
        main_vld_d = 1'b1;
      end else if (!skid_vld_q) begin
        skid_d     = push_entry_i;
        skid_vld_d = 1'b1;
      end
      // Push into a full buffer cannot occur: requests are gated on skid empty.
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign main_entry_o = main_q;
  assign valid_o      = main_vld_q;
  assign full_o       = skid_vld_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs the imem request/response handshake
// and feeds IF/ID through a two-entry buffer, with redirect and halt handling.
module fetch_ctrl
  import fetch_defs::*;
#(
  parameter logic [15:0] RESET_PC = DefResetPc,
  parameter logic [15:0] NOP_INST = DefNopInst
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] pc,
  output logic [15:0] inst,
  output logic        inst_valid,
  output logic [15:0] inst_pc,
  output logic [15:0] inst_pc_2,
  output logic        err
);

  fetch_state_e state_q;
  logic [15:0]  pc_q;
  logic [15:0]  req_pc_q;
  logic         err_q;

  logic         buf_valid;
  logic         buf_full;
  fetch_entry_t main_entry;
  fetch_entry_t push_entry;
  logic         accept;
  logic         push;
  logic         pop;
  logic         flush;

  // Request handshake and buffer control.
  always_comb begin
    imem_rd = (state_q == StFetch) && !buf_full;
    accept  = imem_rd && !imem_stall;
    push    = 1'b0;
    unique case (state_q)
      StFetch: push = accept && imem_done;
      StWait:  push = imem_done;
      default: push = 1'b0;
    endcase
    // Any response landing in a redirect/halt cycle belongs to the flushed stream.
    if (redirect || halt) begin
      push = 1'b0;
    end
    flush           = redirect || halt;
    pop             = buf_valid && !stall;
    push_entry.inst = imem_data;
    push_entry.pc   = (state_q == StFetch) ? pc_q : req_pc_q;
  end

  // FSM, fetch PC, outstanding-request address and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (redirect) begin
            pc_q  <= align_pc(redirect_pc);
            err_q <= err_q | redirect_pc[0];
            // A request accepted in this cycle is still in flight and must be drained.
            state_q <= (accept && !imem_done) ? StDrain : StFetch;
          end else if (halt) begin
            state_q <= StHalted;
          end else if (accept) begin
            pc_q     <= pc_q + 16'd2;
            req_pc_q <= pc_q;
            if (!imem_done) begin
              state_q <= StWait;
            end
          end
        end
        StWait, StDrain: begin
          if (redirect) begin
            pc_q    <= align_pc(redirect_pc);
            err_q   <= err_q | redirect_pc[0];
            state_q <= imem_done ? StFetch : StDrain;
          end else if (halt) begin
            state_q <= StHalted;
          end else if (imem_done) begin
            state_q <= StFetch;
          end
        end
        StHalted: state_q <= StHalted;
        default:  state_q <= StFetch;
      endcase
    end
  end

  fetch_skid_buf u_buf (
    .clk_i        (clk),
    .rst_ni       (rst),
    .flush_i      (flush),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .main_entry_o (main_entry),
    .valid_o      (buf_valid),
    .full_o       (buf_full)
  );

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign err        = err_q;
  assign inst_valid = buf_valid;
  assign inst       = buf_valid ? main_entry.inst : NOP_INST;
  assign inst_pc    = main_entry.pc;
  assign inst_pc_2  = main_entry.pc + 16'd2;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change 1ns after the rising edge,
// outputs are checked there as well.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        inst_valid;
  logic [15:0] inst_pc;
  logic [15:0] inst_pc_2;
  logic        err;

  logic        zw;      // zero-wait memory model: data = 0xC000 | address
  logic [15:0] dat_r;   // directed data for slow responses

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = zw ? (16'hC000 | imem_addr) : dat_r;

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_stall (imem_stall),
    .imem_done  (imem_done),
    .imem_data  (imem_data),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_pc    (inst_pc),
    .inst_pc_2  (inst_pc_2),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; imem_stall = 1'b0; imem_done = 1'b0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0; zw = 1'b0; dat_r = 16'h0;
    #12;
    // Reset state
    chk("rst_pc", pc, 16'h0000);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 16'h0800);
    chk("rst_inst_pc", inst_pc, 16'h0000);
    chk("rst_inst_pc_2", inst_pc_2, 16'h0002);
    chk("rst_err", err, 1'b0);

    // Zero-wait stream
    zw = 1'b1; imem_done = 1'b1;
    rst = 1'b1;
    chk("zw_rd0", imem_rd, 1'b1);
    chk("zw_addr0", imem_addr, 16'h0000);
    tick();
    chk("zw_pc1", pc, 16'h0002);
    chk("zw_v1", inst_valid, 1'b1);
    chk("zw_ipc1", inst_pc, 16'h0000);
    chk("zw_inst1", inst, 16'hC000);
    tick();
    chk("zw_pc2", pc, 16'h0004);
    chk("zw_ipc2", inst_pc, 16'h0002);
    chk("zw_ipc2_2", inst_pc_2, 16'h0004);
    tick();
    chk("zw_pc3", pc, 16'h0006);
    chk("zw_ipc3", inst_pc, 16'h0004);
    for (int i = 0; i < 5; i++) tick();
    chk("zw_pc_10", pc, 16'h0010);
    chk("zw_ipc_e", inst_pc, 16'h000E);

    // Memory busy 3 cycles, then response 2 cycles after accept
    zw = 1'b0; imem_done = 1'b0; imem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ms_pc_hold", pc, 16'h0010);
      chk("ms_rd", imem_rd, 1'b1);
    end
    chk("ms_bubble", inst_valid, 1'b0);
    imem_stall = 1'b0;
    tick();
    chk("ms_acc_pc", pc, 16'h0012);
    chk("ms_wait_rd", imem_rd, 1'b0);
    tick();
    chk("ms_wait_rd2", imem_rd, 1'b0);
    chk("ms_wait_v", inst_valid, 1'b0);
    imem_done = 1'b1; dat_r = 16'h1234;
    tick();
    imem_done = 1'b0;
    chk("ms_v", inst_valid, 1'b1);
    chk("ms_inst", inst, 16'h1234);
    chk("ms_ipc", inst_pc, 16'h0010);
    chk("ms_pc", pc, 16'h0012);
    chk("ms_rd_back", imem_rd, 1'b1);

    // Downstream stall 4 cycles with zero-wait memory
    stall = 1'b1; zw = 1'b1; imem_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("st_rd", imem_rd, 1'b0);
      chk("st_pc", pc, 16'h0014);
      chk("st_inst", inst, 16'h1234);
      chk("st_ipc", inst_pc, 16'h0010);
    end
    stall = 1'b0;
    tick();
    chk("st_d1_inst", inst, 16'hC012);
    chk("st_d1_ipc", inst_pc, 16'h0012);
    chk("st_d1_rd", imem_rd, 1'b1);
    tick();
    chk("st_d2_inst", inst, 16'hC014);
    chk("st_d2_ipc", inst_pc, 16'h0014);
    chk("st_d2_pc", pc, 16'h0016);

    // Redirect while waiting for a response
    zw = 1'b0; imem_done = 1'b0;
    tick();
    chk("rw_wait_rd", imem_rd, 1'b0);
    chk("rw_pc", pc, 16'h0018);
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    chk("rw_v", inst_valid, 1'b0);
    chk("rw_pc_new", pc, 16'h0100);
    chk("rw_drain_rd", imem_rd, 1'b0);
    tick();
    chk("rw_drain_rd2", imem_rd, 1'b0);
    imem_done = 1'b1; dat_r = 16'hDEAD;
    tick();
    imem_done = 1'b0;
    chk("rw_discard_v", inst_valid, 1'b0);
    chk("rw_rd", imem_rd, 1'b1);
    chk("rw_addr", imem_addr, 16'h0100);

    // PC wrap at top of address space
    imem_stall = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    chk("wr_pc", pc, 16'hFFFE);
    imem_stall = 1'b0; zw = 1'b1; imem_done = 1'b1;
    tick();
    chk("wr_pc_wrap", pc, 16'h0000);
    chk("wr_inst", inst, 16'hFFFE);
    chk("wr_ipc", inst_pc, 16'hFFFE);
    chk("wr_ipc_2", inst_pc_2, 16'h0000);

    // Misaligned redirect together with halt: redirect wins
    imem_stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0101; halt = 1'b1;
    tick();
    redirect = 1'b0; halt = 1'b0; imem_stall = 1'b0;
    chk("mr_pc", pc, 16'h0100);
    chk("mr_err", err, 1'b1);
    chk("mr_v", inst_valid, 1'b0);
    chk("mr_rd", imem_rd, 1'b1);
    tick();
    chk("mr_inst", inst, 16'hC100);
    chk("mr_ipc", inst_pc, 16'h0100);
    chk("mr_err_sticky", err, 1'b1);

    // Halt
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("h_v", inst_valid, 1'b0);
    chk("h_rd", imem_rd, 1'b0);
    chk("h_pc", pc, 16'h0102);
    redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h_rd_forever", imem_rd, 1'b0);
      chk("h_v_forever", inst_valid, 1'b0);
      chk("h_pc_hold", pc, 16'h0102);
    end
    chk("h_err", err, 1'b1);

    // Asynchronous reset while waiting
    rst = 1'b0; #3; rst = 1'b1;
    zw = 1'b0; imem_done = 1'b0; imem_stall = 1'b0;
    tick();
    chk("ar_wait_pc", pc, 16'h0002);
    chk("ar_wait_rd", imem_rd, 1'b0);
    imem_done = 1'b1; dat_r = 16'hBEEF;
    #2 rst = 1'b0;
    #1;
    chk("ar_pc", pc, 16'h0000);
    chk("ar_v", inst_valid, 1'b0);
    chk("ar_err", err, 1'b0);
    chk("ar_inst", inst, 16'h0800);
    chk("ar_rd", imem_rd, 1'b1);
    tick();
    imem_stall = 1'b1;
    rst = 1'b1;
    tick();
    chk("ar_stale_v", inst_valid, 1'b0);
    chk("ar_stale_pc", pc, 16'h0000);
    imem_stall = 1'b0; imem_done = 1'b0;
    tick();
    chk("ar_refetch_pc", pc, 16'h0002);
    chk("ar_refetch_rd", imem_rd, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
